btn_event_decoder: RTL and testbench
====================================

# btn_event_decoder

Converts the debounced, synchronized button level into one-cycle event pulses: press, release, short click, double click, long press and auto-repeat. It sits directly downstream of the button debouncer, on its clean output, and feeds UI and control logic that needs discrete events rather than a level. All timing is in clk cycles, and all outputs are registered.

## Interface
- LONG_CYCLES, 25_000_000: cycles the button must stay held, counted from press_pulse, before long_press fires.
- REPEAT_CYCLES, 5_000_000: period between repeat_pulse events while in long-hold.
- DCLICK_CYCLES, 12_500_000: window after a release in which a second press counts toward a double click.
- CNT_W, 25: counter width. Must hold max(param)-1. Every parameter must be ≥2.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high; clock clk.
- btn_level  in  1  clean, already-synchronized button level (1 = pressed).
- press_pulse  out  1  one-cycle pulse on each accepted press.
- release_pulse  out  1  one-cycle pulse on each accepted release.
- short_click  out  1  one-cycle pulse: a single short press with no second press inside the window.
- double_click  out  1  one-cycle pulse: a second short press released inside the window.
- long_press  out  1  one-cycle pulse when the hold time reaches LONG_CYCLES.
- repeat_pulse  out  1  periodic one-cycle pulse during long-hold.
- held  out  1  level; 1 while the FSM is in DOWN, DOWN2 or LONG.

## Operation
- Edge detection uses a single register btn_q: rise = btn_level & ~btn_q, fall = ~btn_level & btn_q.
- FSM states are IDLE, DOWN, GAP, DOWN2 and LONG. A single counter cnt is cleared on every state transition.
- IDLE
  - rise: press_pulse, go to DOWN.
  - fall: ignored.
- DOWN (cnt increments each cycle)
  - fall: release_pulse, go to GAP.
  - cnt==LONG_CYCLES-1 with no fall: long_press, go to LONG.
- GAP (cnt increments)
  - rise: press_pulse, go to DOWN2.
  - cnt==DCLICK_CYCLES-1 with no rise: short_click, go to IDLE.
- DOWN2 (cnt increments)
  - fall: release_pulse and double_click in the same cycle, go to IDLE.
  - cnt==LONG_CYCLES-1: long_press, go to LONG. The pending first click is discarded.
- LONG (cnt increments)
  - cnt==REPEAT_CYCLES-1: repeat_pulse, cnt←0.
  - fall: release_pulse, go to IDLE. No click event is emitted.
- Simultaneous events: an input edge always wins over a counter threshold in the same cycle.
  - Fall at the long threshold counts as a short press.
  - Rise at GAP timeout goes to DOWN2; no short_click.
  - Fall at the repeat threshold: release_pulse only, no repeat_pulse.
- At most one of short_click, double_click and long_press is asserted per cycle.

## Timing
- Reset values: all pulse outputs 0, held 0, state IDLE, cnt 0, btn_q 1.
  - Because btn_q resets to 1, a button held through reset is ignored until it is released and pressed again.
- press_pulse is asserted in the cycle after the edge where btn_level is first sampled high. release_pulse behaves the same way for low.
- long_press is asserted exactly LONG_CYCLES cycles after the press_pulse cycle.
- The first repeat_pulse comes REPEAT_CYCLES cycles after long_press, then every REPEAT_CYCLES cycles.
- short_click is asserted exactly DCLICK_CYCLES cycles after release_pulse.
- held rises together with press_pulse and falls together with release_pulse.
- Reset asserted mid-operation: outputs clear immediately (asynchronous). No pulse is emitted on reset release.
- cnt never wraps. Every state exits or reloads cnt at its threshold.

## Structure
- Shared package btn_pkg holds:
  - the state enum (IDLE, DOWN, GAP, DOWN2, LONG);
  - default timing constants;
  - a CNT_W helper function computing $clog2 of the largest parameter.
- Sub-module btn_edge_detect contains btn_q (reset value 1) and produces rise and fall. The rest is a single FSM plus counter in btn_event_decoder.

## Test plan
Sim parameters: LONG=20, REPEAT=5, DCLICK=8.
- Reset-held button: btn_level=1 through reset release, held 30 cycles, then 0 → no outputs. A new rise → press_pulse one cycle later.
- Single click: press 5 cycles, release → press_pulse, then release_pulse; short_click exactly 8 cycles after release_pulse; held high for 5 cycles.
- Double click: press 3, low 4, press 3, release → 2 press_pulse, 2 release_pulse, double_click coincident with the second release_pulse, no short_click.
- Long and repeat: hold 40 cycles → long_press at press+20, repeat_pulse at +25, +30 and +35; release → release_pulse only.
- Boundary edges:
  - fall on the cycle cnt==19 in DOWN → release_pulse, no long_press;
  - rise on the cycle cnt==7 in GAP → DOWN2, no short_click.
- Reset mid-LONG with the button still held → all outputs 0 immediately. After reset release, no pulses until the button is released and pressed again.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and timing defaults for the button event decoder.
package btn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDown,
        StGap,
        StDown2,
        StLong
    } state_e;

    typedef struct packed {
        logic press_pulse;
        logic release_pulse;
        logic short_click;
        logic double_click;
        logic long_press;
        logic repeat_pulse;
    } events_t;

    localparam int unsigned LongCyclesDef   = 25_000_000;
    localparam int unsigned RepeatCyclesDef = 5_000_000;
    localparam int unsigned DclickCyclesDef = 12_500_000;

    // Enough bits to hold (largest threshold - 1).
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/btn_event_decoder_if.sv
// Button level in, discrete event pulses out.
interface btn_event_decoder_if;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic short_click;
    logic double_click;
    logic long_press;
    logic repeat_pulse;
    logic held;

    modport master (
        input  btn_level,
        output press_pulse, release_pulse, short_click, double_click,
               long_press, repeat_pulse, held
    );

    modport slave (
        output btn_level,
        input  press_pulse, release_pulse, short_click, double_click,
               long_press, repeat_pulse, held
    );
endinterface

// File: rtl/btn_edge_detect.sv
// Rise/fall detection on the clean button level; btn_q resets high so a button
// held through reset is not reported as a press.
module btn_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic rise,
    output logic fall
);
    logic btn_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) btn_q <= 1'b1;
        else       btn_q <= btn_level;
    end

    assign rise = btn_level & ~btn_q;
    assign fall = ~btn_level & btn_q;
endmodule

// File: rtl/btn_event_decoder.sv
// Turns the debounced button level into press/release/click/long/repeat pulses.
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = LongCyclesDef,
    parameter int unsigned REPEAT_CYCLES = RepeatCyclesDef,
    parameter int unsigned DCLICK_CYCLES = DclickCyclesDef,
    parameter int unsigned CNT_W         = cnt_width(LONG_CYCLES, REPEAT_CYCLES, DCLICK_CYCLES)
) (
    input logic               clk,
    input logic               reset,
    btn_event_decoder_if.master bus
);
    localparam logic [CNT_W-1:0] LongLim   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepeatLim = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DclickLim = CNT_W'(DCLICK_CYCLES - 1);

    logic             rise;
    logic             fall;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    events_t          ev_q, ev_d;
    logic             held_q, held_d;

    btn_edge_detect u_edge (
        .clk       (clk),
        .reset     (reset),
        .btn_level (bus.btn_level),
        .rise      (rise),
        .fall      (fall)
    );

    // Input edges are tested before counter thresholds so an edge always wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        ev_d    = '0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rise) begin
                    ev_d.press_pulse = 1'b1;
                    state_d          = StDown;
                end
            end
            StDown: begin
                if (fall) begin
                    ev_d.release_pulse = 1'b1;
                    state_d            = StGap;
                end else if (cnt_q == LongLim) begin
                    ev_d.long_press = 1'b1;
                    state_d         = StLong;
                end
            end
            StGap: begin
                if (rise) begin
                    ev_d.press_pulse = 1'b1;
                    state_d          = StDown2;
                end else if (cnt_q == DclickLim) begin
                    ev_d.short_click = 1'b1;
                    state_d          = StIdle;
                end
            end
            StDown2: begin
                if (fall) begin
                    ev_d.release_pulse = 1'b1;
                    ev_d.double_click  = 1'b1;
                    state_d            = StIdle;
                end else if (cnt_q == LongLim) begin
                    ev_d.long_press = 1'b1;
                    state_d         = StLong;
                end
            end
            StLong: begin
                if (fall) begin
                    ev_d.release_pulse = 1'b1;
                    state_d            = StIdle;
                end else if (cnt_q == RepeatLim) begin
                    ev_d.repeat_pulse = 1'b1;
                    cnt_d             = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
        held_d = (state_d == StDown) || (state_d == StDown2) || (state_d == StLong);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ev_q    <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ev_q    <= ev_d;
            held_q  <= held_d;
        end
    end

    assign bus.press_pulse   = ev_q.press_pulse;
    assign bus.release_pulse = ev_q.release_pulse;
    assign bus.short_click   = ev_q.short_click;
    assign bus.double_click  = ev_q.double_click;
    assign bus.long_press    = ev_q.long_press;
    assign bus.repeat_pulse  = ev_q.repeat_pulse;
    assign bus.held          = held_q;
endmodule

// File: tb/tb_btn_event_decoder.sv
// Randomized and directed stimulus against a timestamp-based gesture model.
module tb_btn_event_decoder;
    localparam int unsigned L = 20;
    localparam int unsigned R = 5;
    localparam int unsigned D = 8;

    logic clk;
    logic reset;
    btn_event_decoder_if bus ();

    btn_event_decoder #(
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (R),
        .DCLICK_CYCLES (D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    logic [6:0] exp_q[$];

    // Model: gesture described by "is down", pending clicks, long-hold flag and
    // the cycle stamp of the last event that starts a timing window.
    int   now;
    int   m_stamp;
    int   m_clicks;
    logic m_down;
    logic m_long;
    logic m_prev;

    function automatic logic [6:0] outs();
        return {bus.press_pulse, bus.release_pulse, bus.short_click, bus.double_click,
                bus.long_press, bus.repeat_pulse, bus.held};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got p/r/s/d/l/rp/h=%b want %b", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input logic b, input logic r);
        logic rise, fall, was_reset;
        logic e_press, e_rel, e_short, e_dbl, e_long, e_rep;
        int   age;
        @(negedge clk);
        was_reset = reset;
        reset     = r;
        bus.btn_level = b;
        now++;
        {e_press, e_rel, e_short, e_dbl, e_long, e_rep} = '0;
        if (r) begin
            m_down = 0; m_long = 0; m_clicks = 0; m_prev = 1'b1;
        end else begin
            rise   = b & ~m_prev;
            fall   = ~b & m_prev;
            m_prev = b;
            age    = now - m_stamp;
            if (!m_down) begin
                if (rise) begin
                    e_press = 1; m_down = 1; m_stamp = now;
                end else if (m_clicks == 1 && age == D) begin
                    e_short = 1; m_clicks = 0;
                end
            end else if (fall) begin
                e_rel  = 1;
                m_down = 0;
                if (m_long) begin
                    m_long = 0; m_clicks = 0;
                end else if (m_clicks == 1) begin
                    e_dbl = 1; m_clicks = 0;
                end else begin
                    m_clicks = 1; m_stamp = now;
                end
            end else if (m_long) begin
                if (age == R) begin e_rep = 1; m_stamp = now; end
            end else if (age == L) begin
                e_long = 1; m_long = 1; m_clicks = 0; m_stamp = now;
            end
        end
        exp_q.push_back({e_press, e_rel, e_short, e_dbl, e_long, e_rep, m_down});
        if (r && !was_reset) begin
            #1 check("async_reset", outs(), 7'b0);
        end
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) cycle(b, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents a registered output vector.
    initial begin
        logic [6:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", outs(), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got timeout want finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0; now = 0; m_stamp = 0; m_clicks = 0;
        m_down = 0; m_long = 0; m_prev = 1'b1;
        reset = 1'b1;
        bus.btn_level = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        // Held through reset, then released, then a single click.
        hold(1, 30); hold(0, 5);
        hold(1, 5);  hold(0, 12);
        // Double click.
        hold(1, 3); hold(0, 4); hold(1, 3); hold(0, 12);
        // Long press with repeats.
        hold(1, 40); hold(0, 12);
        // Fall exactly at the long threshold, rise exactly at the gap timeout.
        hold(1, 20); hold(0, 8); hold(1, 3); hold(0, 12);
        // Reset mid-long with the button still held.
        hold(1, 30);
        cycle(1'b1, 1'b1); cycle(1'b1, 1'b1);
        hold(1, 10); hold(0, 5); hold(1, 5); hold(0, 12);
        for (int i = 0; i < 60; i++) begin
            hold(1, $urandom_range(1, 45));
            hold(0, $urandom_range(1, 14));
        end
        hold(0, 30);
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
